alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU instance between N_REQ requesters (e.g. execute stage, branch/CSR unit).
//  - Arbitrates valid/ready requests, either round-robin or fixed priority.
//  - Registers the ALU result into a single response slot tagged with the requester index.
//  - Sits between the issuing units and the ALU; the ALU stays purely combinational.
// PARAMETERS
//  N_REQ   2  number of requesters, 2..8
//  RR      1  1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//  i_clock        in   1              single clock, rising edge
//  i_reset        in   1              synchronous, active-high reset
//  i_req_valid    in   N_REQ          request valid, one bit per requester
//  o_req_ready    out  N_REQ          request accepted this cycle (at most one bit set)
//  i_req_op       in   N_REQ x AluOp  operation per requester
//  i_req_dataA    in   N_REQ x Data   operand A per requester
//  i_req_dataB    in   N_REQ x Data   operand B per requester
//  o_rsp_valid    out  1              response slot holds a result
//  i_rsp_ready    in   1              consumer takes the response
//  o_rsp_id       out  ReqId          index of the requester that owns the result
//  o_rsp_result   out  Data           registered ALU result
// BEHAVIOUR
//  Reset (sync, i_reset=1 at clock edge):
//   - o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, last-grant pointer = N_REQ-1.
//   - Reset mid-operation drops any held response; no o_req_ready during a reset cycle.
//  Slot and grant:
//   - slot_free = ~o_rsp_valid | i_rsp_ready.
//   - RR=1: winner is the first valid index after the last-grant pointer, wrapping modulo N_REQ.
//   - RR=0: winner is the lowest valid index.
//   - o_req_ready[k] = (k==winner) & slot_free & ~i_reset. This is combinational from
//     i_req_valid; requesters must not derive valid from ready.
//  Transfer (valid&ready on port k), at the next edge:
//   - o_rsp_result <= ALU(op[k],dataA[k],dataB[k]), o_rsp_id <= k, o_rsp_valid <= 1.
//   - Last-grant pointer <= k.
//   - Latency is exactly one cycle from accept to o_rsp_valid.
//  Response handling:
//   - Held response with i_rsp_ready=1 and no new transfer: o_rsp_valid <= 0.
//   - Held response with i_rsp_ready=1 and a new transfer in the same cycle: back-to-back,
//     o_rsp_valid stays 1 and the new result replaces the old. Throughput is 1 op per cycle.
//   - o_rsp_valid=1 with i_rsp_ready=0: no grant; result, id and valid are held stable.
//  Requester rules:
//   - A requester holding valid without ready must keep op and operands stable;
//     the arbiter latches nothing before accept.
//   - The pointer moves only on transfer; no valid requests means no grant and no state change.
//  Width rules:
//   - Data is the 32-bit Types::Data; ReqId = $clog2(N_REQ) bits, minimum 1.
//   - Shift amount is dataB[4:0], as in the ALU.
// STRUCTURE
//  - Types package gains `typedef logic [$clog2(N_REQ)-1:0] ReqId` (sized for max 8)
//    and `localparam MAX_REQ = 8`.
//  - One new sub-module: round_robin_picker (combinational; inputs req vector and last
//    pointer; outputs one-hot grant and index).
//  - The existing ALU is instanced once, fed through an operand mux driven by winner.
// TESTING
//  1. Reset: hold i_reset 2 cycles with all req valid -> o_req_ready=0 and o_rsp_valid=0
//     throughout; after release, port 0 is granted first.
//  2. Single op: port1 ADD 5,7 -> ready[1] same cycle; next cycle rsp_valid=1, id=1,
//     result=12.
//  3. RR fairness: N_REQ=2, both valid continuously, rsp_ready=1 -> grants alternate
//     0,1,0,1; SUB 3,5 on port0 gives 0xFFFFFFFE.
//  4. Backpressure: rsp_ready=0 for 3 cycles with both requesters valid -> no ready
//     asserted; result and id held; on release, the next grant goes to the other index.
//  5. Fixed priority: RR=0, both valid 4 cycles -> port0 wins every cycle; SLT 0xFFFFFFFF,1
//     gives result 1.
//  6. Reset mid-op: reset asserted while rsp_valid=1, rsp_ready=0 -> next cycle
//     rsp_valid=0 and the pointer is back to N_REQ-1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, data/id widths and the
// combinational ALU function that the arbiter instances once.
package alu_arbiter_pkg;

  localparam int MAX_REQ = 8;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;

  typedef logic [DATA_W-1:0]          data_t;
  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  // Shift amount is only the low five bits of operand B.
  function automatic data_t alu(input alu_op_e op, input data_t a, input data_t b);
    data_t r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = data_t'($signed(a) >>> b[4:0]);
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: r = {{(DATA_W-1){1'b0}}, a < b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_round_robin_picker.sv
// Combinational winner select: round-robin after the last grant, or lowest
// valid index when RR=0. Outputs one-hot grant plus encoded index.
module round_robin_picker
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int RR    = 1,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan candidates from lowest priority to highest so the last hit wins.
  always_comb begin
    int k;
    k     = 0;
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = (RR != 0) ? ((int'(last) + i) % N_REQ) : (i - 1);
      if (req[k]) begin
        idx = ID_W'(k);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ valid/ready requesters and
// registers the result into a single id-tagged response slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int RR    = 1,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ-1:0][OP_W-1:0] i_req_op,
  input  data_t [N_REQ-1:0]          i_req_dataA,
  input  data_t [N_REQ-1:0]          i_req_dataB,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_W-1:0]            o_rsp_id,
  output data_t                      o_rsp_result
);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  last;
  logic             any;
  logic             slot_free;
  logic             fire;
  data_t            alu_res;

  round_robin_picker #(.N_REQ(N_REQ), .RR(RR), .ID_W(ID_W)) u_pick (
    .req   (i_req_valid),
    .last  (last),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign slot_free   = ~o_rsp_valid | i_rsp_ready;
  assign fire        = any & slot_free & ~i_reset;
  assign o_req_ready = fire ? grant : '0;

  // Operand mux in front of the single ALU instance.
  assign alu_res = alu(alu_op_e'(i_req_op[win]), i_req_dataA[win], i_req_dataB[win]);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
      last         <= ID_W'(N_REQ - 1);
    end else if (fire) begin
      o_rsp_valid  <= 1'b1;
      o_rsp_id     <= win;
      o_rsp_result <= alu_res;
      last         <= win;
    end else if (i_rsp_ready) begin
      o_rsp_valid  <= 1'b0;
    end
  end

endmodule
